// File: rtl/pipe_stage_reg.sv
// Two-entry pipeline stage (head + skid) with registered outputs, flush/freeze
// control and a saturating count of entries discarded by flush.
module pipe_stage_reg #(
    parameter int unsigned DATA_W       = 32,
    parameter bit          ZERO_INVALID = 1'b1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              freeze,
    output logic [1:0]        count,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int unsigned SUM_W = CNT_W + 2;

    // Occupancy as {head_valid, skid_valid}; skid without head cannot occur.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'b00,
        OCC_ONE   = 2'b10,
        OCC_FULL  = 2'b11
    } occ_t;

    logic              head_valid;
    logic              skid_valid;
    logic [DATA_W-1:0] head_data;
    logic [DATA_W-1:0] skid_data;
    logic [CNT_W-1:0]  flush_cnt_q;

    logic              accept;
    logic              emit;
    logic [1:0]        held;
    occ_t              occ;
    logic [SUM_W-1:0]  cnt_sum;
    logic [CNT_W-1:0]  cnt_next;

    assign in_ready  = !skid_valid && !freeze && !flush;
    assign out_valid = head_valid && !freeze && !flush;
    assign out_data  = head_data;
    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;
    assign held      = {1'b0, head_valid} + {1'b0, skid_valid};
    assign occ       = occ_t'({head_valid, skid_valid});
    assign count     = held;
    assign flush_cnt = flush_cnt_q;

    // Two spare bits absorb the carry so saturation is a simple overflow test.
    always_comb begin
        cnt_sum  = SUM_W'(flush_cnt_q) + SUM_W'(held);
        cnt_next = cnt_sum[CNT_W-1:0];
        if (cnt_sum[SUM_W-1:CNT_W] != '0) begin
            cnt_next = '1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_valid  <= 1'b0;
            skid_valid  <= 1'b0;
            head_data   <= '0;
            skid_data   <= '0;
            flush_cnt_q <= '0;
        end else if (flush) begin
            head_valid  <= 1'b0;
            skid_valid  <= 1'b0;
            flush_cnt_q <= cnt_next;
            if (ZERO_INVALID) begin
                head_data <= '0;
                skid_data <= '0;
            end
        end else if (!freeze) begin
            case (occ)
                OCC_EMPTY: begin
                    if (accept) begin
                        head_data  <= in_data;
                        head_valid <= 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (accept && emit) begin
                        head_data <= in_data;
                    end else if (accept) begin
                        skid_data  <= in_data;
                        skid_valid <= 1'b1;
                    end else if (emit) begin
                        head_valid <= 1'b0;
                        if (ZERO_INVALID) begin
                            head_data <= '0;
                        end
                    end
                end
                OCC_FULL: begin
                    if (emit) begin
                        head_data  <= skid_data;
                        skid_valid <= 1'b0;
                        if (ZERO_INVALID) begin
                            skid_data <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: streaming, backpressure, flush, freeze,
// flush counter saturation (narrow instance) and asynchronous reset.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, flush, freeze;
    logic [31:0] in_data, out_data;
    logic [1:0]  count;
    logic [15:0] flush_cnt;

    logic        s_rst;
    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_flush, s_freeze;
    logic [7:0]  s_in_data, s_out_data;
    logic [1:0]  s_count;
    logic [1:0]  s_flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .ZERO_INVALID(1'b1), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .flush(flush), .freeze(freeze), .count(count), .flush_cnt(flush_cnt)
    );

    pipe_stage_reg #(.DATA_W(8), .ZERO_INVALID(1'b1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(s_rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .flush(s_flush), .freeze(s_freeze), .count(s_count), .flush_cnt(s_flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int n, input logic [31:0] base);
        out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + 32'(i);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic s_fill2(input logic [7:0] base);
        s_out_ready = 1'b0;
        s_in_valid  = 1'b1;
        s_in_data   = base;
        step();
        s_in_data   = base + 8'd1;
        step();
        s_in_valid  = 1'b0;
    endtask

    initial begin
        logic [1:0] sat_exp [4];
        sat_exp = '{2'd2, 2'd3, 2'd3, 2'd3};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        flush = 1'b0; freeze = 1'b0;
        s_rst = 1'b1; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
        s_flush = 1'b0; s_freeze = 1'b0;

        // reset state
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_count", count, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        freeze = 1'b1;
        #1;
        chk("rst_in_ready_freeze", in_ready, 0);
        freeze = 1'b0;
        step();
        step();
        rst = 1'b0;
        s_rst = 1'b0;

        // streaming 1..4, no bypass: out_valid low before first edge
        in_valid = 1'b1; in_data = 32'd1; out_ready = 1'b1;
        #1;
        chk("stream_no_bypass", out_valid, 0);
        for (int i = 1; i <= 4; i++) begin
            in_data = 32'(i);
            #1;
            chk("stream_in_ready", in_ready, 1);
            step();
            chk("stream_out_data", out_data, 32'(i));
            chk("stream_count", count, 1);
            chk("stream_out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_drain_count", count, 0);
        chk("stream_drain_zero", out_data, 0);

        // backpressure A, B, C
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA;
        step();
        chk("bp_count_a", count, 1);
        in_data = 32'hB;
        step();
        chk("bp_count_ab", count, 2);
        chk("bp_in_ready_full", in_ready, 0);
        in_data = 32'hC;
        step();
        chk("bp_hold_count", count, 2);
        chk("bp_hold_head", out_data, 32'hA);
        out_ready = 1'b1;
        step();
        chk("bp_emit_a_head", out_data, 32'hB);
        chk("bp_emit_a_count", count, 1);
        chk("bp_emit_a_ready", in_ready, 1);
        step();
        chk("bp_emit_b_head", out_data, 32'hC);
        chk("bp_emit_b_count", count, 1);
        in_valid = 1'b0;
        step();
        chk("bp_emit_c_count", count, 0);
        chk("bp_emit_c_data", out_data, 0);

        // flush counter build-up to 5, including an empty flush
        fill(2, 32'h100);
        do_flush();
        chk("fl_cnt_2", flush_cnt, 2);
        chk("fl_count_0", count, 0);
        fill(2, 32'h200);
        do_flush();
        chk("fl_cnt_4", flush_cnt, 4);
        fill(1, 32'h300);
        do_flush();
        chk("fl_cnt_5", flush_cnt, 5);
        do_flush();
        chk("fl_empty_cnt", flush_cnt, 5);

        // flush overrides freeze, and blocks accept
        fill(2, 32'hA0);
        freeze = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 32'hBAD;
        #1;
        chk("flfz_in_ready", in_ready, 0);
        chk("flfz_out_valid", out_valid, 0);
        step();
        flush = 1'b0; freeze = 1'b0; in_valid = 1'b0;
        #1;
        chk("flfz_count", count, 0);
        chk("flfz_out_valid_after", out_valid, 0);
        chk("flfz_out_data", out_data, 0);
        chk("flfz_cnt_7", flush_cnt, 7);

        // freeze holds state for 3 cycles
        fill(1, 32'hDEADBEEF);
        freeze = 1'b1; in_valid = 1'b1; in_data = 32'h12345678; out_ready = 1'b1;
        #1;
        chk("fz_in_ready", in_ready, 0);
        chk("fz_out_valid", out_valid, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fz_count", count, 1);
            chk("fz_head", out_data, 32'hDEADBEEF);
        end
        freeze = 1'b0; in_valid = 1'b0;
        #1;
        chk("fz_rel_valid", out_valid, 1);
        chk("fz_rel_data", out_data, 32'hDEADBEEF);
        step();
        chk("fz_rel_emitted", count, 0);

        // asynchronous reset mid-transfer
        fill(2, 32'h77);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", count, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_flush_cnt", flush_cnt, 0);
        step();
        rst = 1'b0;
        in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        chk("post_rst_accept_count", count, 1);
        chk("post_rst_accept_data", out_data, 32'h55);

        // saturation with CNT_W=2
        for (int i = 0; i < 4; i++) begin
            s_fill2(8'(16 * i));
            chk("sat_pre_count", s_count, 2);
            s_flush = 1'b1;
            step();
            s_flush = 1'b0;
            chk("sat_flush_cnt", s_flush_cnt, sat_exp[i]);
        end
        s_fill2(8'h5A);
        #2 s_rst = 1'b1;
        #1;
        chk("sat_rst_count", s_count, 0);
        chk("sat_rst_flush_cnt", s_flush_cnt, 0);
        chk("sat_rst_out_data", s_out_data, 0);
        chk("sat_rst_out_valid", s_out_valid, 0);
        step();
        s_rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
